// File: rtl/approx_add_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : approx_add_err_monitor
// Brief    : Drives operand pairs into an external combinational approximate
//            adder, compares its result to the exact sum and accumulates
//            sample count, error count, worst-case error and summed |error|.
//            Operands come from an exhaustive sweep or a Galois LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module approx_add_err_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 33,
  parameter int ACC_W = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [CNT_W-1:0] n_samples,
  input  logic [2*W-1:0]   seed,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W:0]       add_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W:0]       wce,
  output logic [ACC_W-1:0] sae
);

  localparam int LW = 2 * W;

  // Right-shifting Galois feedback masks. Only the listed widths are known
  // maximal-length; any other width gets a simple nonzero fallback mask.
  function automatic logic [LW-1:0] taps_for_width();
    logic [63:0] t;
    case (LW)
      8:       t = 64'h0000_0000_0000_00B8;   // x^8+x^6+x^5+x^4+1
      16:      t = 64'h0000_0000_0000_B400;   // x^16+x^14+x^13+x^11+1
      32:      t = 64'h0000_0000_8020_0003;   // x^32+x^22+x^2+x+1
      64:      t = 64'hD800_0000_0000_0000;   // x^64+x^63+x^61+x^60+1
      default: t = (64'd1 << (LW - 1)) | 64'd1;
    endcase
    return t[LW-1:0];
  endfunction

  localparam logic [LW-1:0]    C_TAPS      = taps_for_width();
  localparam logic [CNT_W-1:0] C_EXH_TOTAL = {{(CNT_W-LW-1){1'b0}}, 1'b1, {LW{1'b0}}};
  localparam logic [CNT_W-1:0] C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]    C_LFSR_ONE  = {{(LW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN1 = 3'd2,
    S_DRAIN2 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [LW-1:0]      lfsr_q, lfsr_d;
  logic [W-1:0]       add_a_q, add_a_d;
  logic [W-1:0]       add_b_q, add_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               v1_q, v1_d;
  logic [W:0]         o1_q, o1_d;
  logic [W:0]         exact1_q, exact1_d;
  logic [CNT_W-1:0]   samples_q, samples_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [W:0]         wce_q, wce_d;
  logic [ACC_W-1:0]   sae_q, sae_d;

  logic [LW-1:0]      lfsr_step;
  logic [LW-1:0]      seed_nz;
  logic [CNT_W-1:0]   n_nz;
  logic [W:0]         err;
  logic [ACC_W:0]     sae_sum;
  logic               in_run;
  logic               kill;

  // Next-state logic: sequencer FSM, operand generation, capture stage and stats stage
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    total_d   = total_q;
    issued_d  = issued_q;
    lfsr_d    = lfsr_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    done_d    = 1'b0;
    samples_d = samples_q;
    err_cnt_d = err_cnt_q;
    wce_d     = wce_q;
    sae_d     = sae_q;

    // Capture stage: adder output and exact reference for the pair on the bus now
    v1_d      = 1'b0;
    o1_d      = add_o;
    exact1_d  = {1'b0, add_a_q} + {1'b0, add_b_q};

    lfsr_step = {1'b0, lfsr_q[LW-1:1]} ^ (lfsr_q[0] ? C_TAPS : '0);
    seed_nz   = (seed == '0) ? C_LFSR_ONE : seed;
    n_nz      = (n_samples == '0) ? C_CNT_ONE : n_samples;
    err       = (o1_q >= exact1_q) ? (o1_q - exact1_q) : (exact1_q - o1_q);
    sae_sum   = {1'b0, sae_q} + {{(ACC_W-W){1'b0}}, err};
    in_run    = (state_q == S_RUN) || (state_q == S_DRAIN1) || (state_q == S_DRAIN2);
    kill      = abort && in_run;

    // Stats stage: an abort discards whatever is still in flight
    if (v1_q && !kill) begin
      if (samples_q != '1) samples_d = samples_q + C_CNT_ONE;
      if ((err != '0) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + C_CNT_ONE;
      if (err > wce_q) wce_d = err;
      sae_d = sae_sum[ACC_W] ? '1 : sae_sum[ACC_W-1:0];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d   = S_RUN;
          mode_d    = mode;
          total_d   = mode ? n_nz : C_EXH_TOTAL;
          lfsr_d    = seed_nz;
          issued_d  = C_CNT_ONE;
          add_a_d   = mode ? seed_nz[W-1:0]  : '0;
          add_b_d   = mode ? seed_nz[LW-1:W] : '0;
          samples_d = '0;
          err_cnt_d = '0;
          wce_d     = '0;
          sae_d     = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          v1_d = 1'b1;
          if (issued_q == total_q) begin
            state_d = S_DRAIN1;
          end else begin
            issued_d = issued_q + C_CNT_ONE;
            if (mode_q) begin
              lfsr_d  = lfsr_step;
              add_a_d = lfsr_step[W-1:0];
              add_b_d = lfsr_step[LW-1:W];
            end else begin
              add_a_d = issued_q[W-1:0];
              add_b_d = issued_q[LW-1:W];
            end
          end
        end
      end
      S_DRAIN1: state_d = abort ? S_IDLE : S_DRAIN2;
      S_DRAIN2: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN1) || (state_d == S_DRAIN2);
  end

  // State register; a reset abandons any run without a done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      total_q   <= '0;
      issued_q  <= '0;
      lfsr_q    <= C_LFSR_ONE;
      add_a_q   <= '0;
      add_b_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      v1_q      <= 1'b0;
      o1_q      <= '0;
      exact1_q  <= '0;
      samples_q <= '0;
      err_cnt_q <= '0;
      wce_q     <= '0;
      sae_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      total_q   <= total_d;
      issued_q  <= issued_d;
      lfsr_q    <= lfsr_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      v1_q      <= v1_d;
      o1_q      <= o1_d;
      exact1_q  <= exact1_d;
      samples_q <= samples_d;
      err_cnt_q <= err_cnt_d;
      wce_q     <= wce_d;
      sae_q     <= sae_d;
    end
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign samples = samples_q;
  assign err_cnt = err_cnt_q;
  assign wce     = wce_q;
  assign sae     = sae_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_add_err_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_approx_add_err_monitor
// Brief    : Scoreboard bench for approx_add_err_monitor at W=4 with a
//            behavioural adder that is exact, stuck at zero or off by one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_add_err_monitor;

  localparam int W     = 4;
  localparam int CNT_W = 33;
  localparam int ACC_W = 50;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             mode;
  logic [CNT_W-1:0] n_samples;
  logic [2*W-1:0]   seed;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W:0]       add_o;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] err_cnt;
  logic [W:0]       wce;
  logic [ACC_W-1:0] sae;

  // adder behaviour: 0 exact, 1 stuck at zero, 2 exact plus one
  logic [1:0]       add_mode;
  logic [W:0]       exact_sum;

  typedef struct {
    logic [CNT_W-1:0] samples;
    logic [CNT_W-1:0] err_cnt;
    logic [W:0]       wce;
    logic [ACC_W-1:0] sae;
    int               lat;
    int               start_edge;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   tests     = 0;
  int   fails     = 0;
  int   done_seen = 0;
  int   edge_cnt  = 0;

  approx_add_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .n_samples (n_samples),
    .seed      (seed),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_o     (add_o),
    .busy      (busy),
    .done      (done),
    .samples   (samples),
    .err_cnt   (err_cnt),
    .wce       (wce),
    .sae       (sae)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  assign exact_sum = {1'b0, add_a} + {1'b0, add_b};

  always_comb begin
    add_o = exact_sum;
    case (add_mode)
      2'd1:    add_o = '0;
      2'd2:    add_o = exact_sum + 5'd1;
      default: add_o = exact_sum;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input int s, input int ec, input int w, input int sa, input int lat);
    exp_t r;
    r.samples    = CNT_W'(s);
    r.err_cnt    = CNT_W'(ec);
    r.wce        = (W+1)'(w);
    r.sae        = ACC_W'(sa);
    r.lat        = lat;
    r.start_edge = 0;
    return r;
  endfunction

  // Monitor: every done pulse pops one expected result and compares
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_x = sb_q.pop_front();
        check("latency", 64'(edge_cnt - mon_x.start_edge), 64'(mon_x.lat));
        check("samples", 64'(samples), 64'(mon_x.samples));
        check("err_cnt", 64'(err_cnt), 64'(mon_x.err_cnt));
        check("wce",     64'(wce),     64'(mon_x.wce));
        check("sae",     64'(sae),     64'(mon_x.sae));
      end
      done_seen++;
    end
  end

  task automatic issue_run(input logic m, input logic [CNT_W-1:0] n, input logic [2*W-1:0] s,
                           input logic [1:0] am, input logic ab, input logic push, input exp_t e);
    exp_t x;
    @(negedge clk);
    add_mode  = am;
    mode      = m;
    n_samples = n;
    seed      = s;
    start     = 1'b1;
    abort     = ab;
    x = e;
    x.start_edge = edge_cnt;
    if (push) sb_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cyc);
    for (int i = 0; i < max_cyc && done_seen < target; i++) @(negedge clk);
    check("done_reached", 64'(done_seen), 64'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_add_a"},   64'(add_a),   64'd0);
    check({tag, "_add_b"},   64'(add_b),   64'd0);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_done"},    64'(done),    64'd0);
    check({tag, "_samples"}, 64'(samples), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    check({tag, "_wce"},     64'(wce),     64'd0);
    check({tag, "_sae"},     64'(sae),     64'd0);
  endtask

  // LFSR pairs from seed 8'h01 with mask 8'hB8: 01, B8, 5C, 2E, 17
  logic [3:0] exp_a [5] = '{4'h1, 4'h8, 4'hC, 4'hE, 4'h7};
  logic [3:0] exp_b [5] = '{4'h0, 4'hB, 4'h5, 4'h2, 4'h1};

  initial begin
    exp_t none;
    none      = mk_exp(0, 0, 0, 0, 0);
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    mode      = 1'b0;
    n_samples = '0;
    seed      = '0;
    add_mode  = 2'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Exhaustive sweep, exact adder
    issue_run(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, mk_exp(256, 0, 0, 0, 259));
    check("run1_busy", 64'(busy), 64'd1);
    check("run1_a0", 64'(add_a), 64'd0);
    check("run1_b0", 64'(add_b), 64'd0);
    wait_done(1, 300);
    @(negedge clk);
    check("run1_idle_busy", 64'(busy), 64'd0);
    check("run1_hold_samples", 64'(samples), 64'd256);

    // Exhaustive sweep, adder stuck at zero
    issue_run(1'b0, '0, '0, 2'd1, 1'b0, 1'b1, mk_exp(256, 255, 30, 3840, 259));
    wait_done(2, 300);

    // LFSR mode, 5 pairs, adder off by one
    issue_run(1'b1, CNT_W'(5), 8'h01, 2'd2, 1'b0, 1'b1, mk_exp(5, 5, 1, 5, 8));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("lfsr_a%0d", k), 64'(add_a), 64'(exp_a[k]));
      check($sformatf("lfsr_b%0d", k), 64'(add_b), 64'(exp_b[k]));
    end
    wait_done(3, 50);

    // Zero seed and zero count, with abort alongside start (start wins)
    issue_run(1'b1, '0, '0, 2'd0, 1'b1, 1'b1, mk_exp(1, 0, 0, 0, 4));
    check("seed0_busy", 64'(busy), 64'd1);
    check("seed0_a", 64'(add_a), 64'd1);
    check("seed0_b", 64'(add_b), 64'd0);
    wait_done(4, 50);
    repeat (5) @(negedge clk);

    // Abort sampled 10 edges after acceptance; a start during RUN is ignored
    issue_run(1'b0, '0, '0, 2'd1, 1'b0, 1'b0, none);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_samples", 64'(samples), 64'd8);
    check("abort_err_cnt", 64'(err_cnt), 64'd7);
    check("abort_wce", 64'(wce), 64'd7);
    check("abort_sae", 64'(sae), 64'd28);
    repeat (300) @(negedge clk);
    check("abort_frozen", 64'(samples), 64'd8);
    check("abort_no_done", 64'(done_seen), 64'd4);

    // Reset for one cycle mid-run, then a clean restart
    issue_run(1'b0, '0, '0, 2'd1, 1'b0, 1'b0, none);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    issue_run(1'b0, '0, '0, 2'd1, 1'b0, 1'b1, mk_exp(256, 255, 30, 3840, 259));
    check("restart_a0", 64'(add_a), 64'd0);
    check("restart_b0", 64'(add_b), 64'd0);
    @(negedge clk);
    check("restart_a1", 64'(add_a), 64'd1);
    check("restart_b1", 64'(add_b), 64'd0);
    wait_done(5, 300);
    repeat (3) @(negedge clk);
    check("done_total", 64'(done_seen), 64'd5);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
